pwr_seq: RTL and testbench
==========================

PWR_SEQ -- requirements
Module: pwr_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of sequenced enable outputs, legal range 1..16.
REQ-002 SHALL have parameter ON_DELAY, default 10: clk_i cycles between successive stage turn-ons, legal range >=1.
REQ-003 SHALL have parameter OFF_DELAY, default 10: clk_i cycles between successive stage turn-offs, legal range >=1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port arst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_i, input, 1 bit: level request, 1 = power up, 0 = power down.
REQ-007 SHALL have port en_o, output, NUM_STAGES bits: thermometer-coded stage enables; bit 0 turns on first and off last.
REQ-008 SHALL have port on_o, output, 1 bit: all stages enabled and state ON.
REQ-009 SHALL have port off_o, output, 1 bit: no stage enabled and state OFF.
REQ-010 SHALL have port busy_o, output, 1 bit: sequencing in progress (state UP or DOWN).

Function
REQ-011 SHALL implement four states: OFF, UP, ON, DOWN.
REQ-012 SHALL hold a level register L in 0..NUM_STAGES, with en_o[k] = (k < L) for every k.
REQ-013 SHALL hold a cycle counter sized $clog2(max(ON_DELAY,OFF_DELAY)+1) bits, never wrapping.
REQ-014 OFF: req_i=1 at edge T SHALL enter UP with counter=0; otherwise stay OFF.
REQ-015 UP, req_i=1: counter SHALL increment each edge; when the pre-edge counter equals ON_DELAY-1, L SHALL increment and counter SHALL clear, so L steps at edges T+ON_DELAY, T+2*ON_DELAY, and so on.
REQ-016 UP: the edge at which L reaches NUM_STAGES SHALL also enter ON.
REQ-017 UP, req_i=0 sampled: if L>0, SHALL enter DOWN with counter=0 and no L step on that edge; if L=0, SHALL enter OFF.
REQ-018 ON: req_i=0 at edge T SHALL enter DOWN with counter=0; otherwise hold.
REQ-019 DOWN, req_i=0: SHALL mirror REQ-015 using OFF_DELAY and decrementing L; the edge at which L reaches 0 SHALL enter OFF.
REQ-020 DOWN, req_i=1 sampled: if L<NUM_STAGES, SHALL enter UP with counter=0 and no L step on that edge; if L=NUM_STAGES, SHALL enter ON.
REQ-021 A direction reversal SHALL take priority over a step due on the same edge.
REQ-022 All outputs SHALL be registered or decoded from registered state only, with no combinational path from req_i.
REQ-023 busy_o, on_o and off_o SHALL be mutually exclusive, and exactly one SHALL be 1 at all times.

Reset
REQ-024 arst_ni low SHALL immediately force state=OFF, L=0, counter=0.
REQ-025 During and after reset, outputs SHALL be en_o=0, off_o=1, on_o=0, busy_o=0, including when reset asserts mid-sequence.
REQ-026 After reset release, the first edge with req_i=1 SHALL start UP per REQ-014.

Structure
REQ-027 Shared package pwr_seq_pkg SHALL hold the state typedef pwr_seq_state_e (OFF, UP, ON, DOWN).
REQ-028 Sub-module pwr_seq_timer SHALL provide the terminal-count counter, with inputs clear and limit and output tick.
REQ-029 The FSM and level register SHALL reside in pwr_seq.

Verification (NUM_STAGES=4, ON_DELAY=3, OFF_DELAY=2)
REQ-030 Reset test: assert arst_ni mid-run -> en_o=0000, off_o=1, on_o=0, busy_o=0 without waiting for an edge.
REQ-031 Power-up test: req_i=1 sampled at edge 0 -> en_o=0001@3, 0011@6, 0111@9, 1111@12; on_o=1@12; busy_o=1 over edges 0..11.
REQ-032 Power-down test: from ON, req_i=0 sampled at edge 0 -> en_o=0111@2, 0011@4, 0001@6, 0000@8; off_o=1@8.
REQ-033 Reversal test: power up from edge 0, req_i=0 sampled at edge 7 (L=2) -> DOWN@7, en_o=0001@9, 0000@11, off_o=1@11.
REQ-034 Glitch test: 1-cycle req_i pulse sampled at edge 0, low at edge 1 -> OFF@1, en_o stays 0000, busy_o high for exactly one cycle.
REQ-035 Collision test: reversal coinciding with a due step (req_i=0 at edge 6 of REQ-031) -> L stays 1, en_o=0001, state DOWN@6.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg
//   Shared definitions for the power sequencer: the sequencer state type and a
//   small helper used to size the delay counter.
package pwr_seq_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } pwr_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer
//   Terminal-count counter that paces stage steps. Counts up from zero while
//   clear_i is low; tick_o flags the cycle whose count equals limit_i-1, and the
//   counter returns to zero on the following edge, so it never wraps.
// Ports
//   clk_i    : clock, rising edge
//   arst_ni  : asynchronous active-low reset (counter -> 0)
//   clear_i  : hold/force the counter to zero
//   limit_i  : delay in cycles between ticks (>= 1)
//   tick_o   : terminal count reached (decoded from the registered count)
module pwr_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == (limit_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwr_seq.sv
// pwr_seq
//   Power-rail sequencer. A level request ramps a thermometer-coded set of stage
//   enables up (bit 0 first) or down (bit 0 last), one stage every ON_DELAY or
//   OFF_DELAY cycles. A change of request mid-ramp reverses direction at once,
//   taking priority over a step due on the same edge.
// Ports
//   clk_i    : clock, rising edge
//   arst_ni  : asynchronous active-low reset (state OFF, all stages disabled)
//   req_i    : 1 = power up, 0 = power down
//   en_o     : stage enables, en_o[k] = (k < level)
//   on_o     : fully up (state ON)
//   off_o    : fully down (state OFF)
//   busy_o   : ramping (state UP or DOWN)
module pwr_seq
    import pwr_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int ON_DELAY   = 10,
    parameter int OFF_DELAY  = 10
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  req_i,
    output logic [NUM_STAGES-1:0] en_o,
    output logic                  on_o,
    output logic                  off_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(max_int(ON_DELAY, OFF_DELAY) + 1);
    localparam int LVL_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] ON_LIMIT  = CNT_W'(ON_DELAY);
    localparam logic [CNT_W-1:0] OFF_LIMIT = CNT_W'(OFF_DELAY);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(NUM_STAGES);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

    pwr_seq_state_e   state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic             run;
    logic             tick;
    logic [CNT_W-1:0] limit;

    // The counter only runs while continuing in the current ramp direction;
    // any other state or a reversal holds it at zero, so a fresh ramp always
    // starts counting from 0.
    pwr_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clear_i (!run),
        .limit_i (limit),
        .tick_o  (tick)
    );

    assign limit = (state_q == DOWN) ? OFF_LIMIT : ON_LIMIT;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        run     = 1'b0;
        unique case (state_q)
            OFF: begin
                if (req_i) begin
                    state_d = UP;
                end
            end
            UP: begin
                if (!req_i) begin
                    // Reversal wins over any step due on this edge.
                    state_d = (level_q == '0) ? OFF : DOWN;
                end else begin
                    run = 1'b1;
                    if (tick) begin
                        level_d = level_q + LVL_ONE;
                        if (level_d == LVL_FULL) begin
                            state_d = ON;
                        end
                    end
                end
            end
            ON: begin
                if (!req_i) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (req_i) begin
                    state_d = (level_q == LVL_FULL) ? ON : UP;
                end else begin
                    run = 1'b1;
                    if (tick) begin
                        level_d = level_q - LVL_ONE;
                        if (level_d == '0) begin
                            state_d = OFF;
                        end
                    end
                end
            end
            default: begin
                state_d = OFF;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= OFF;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // Outputs decode registered state only; req_i never reaches them directly.
    always_comb begin
        en_o = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            en_o[k] = (LVL_W'(k) < level_q);
        end
    end

    assign on_o   = (state_q == ON);
    assign off_o  = (state_q == OFF);
    assign busy_o = (state_q == UP) || (state_q == DOWN);

endmodule

// File: tb/tb_pwr_seq.sv
// tb_pwr_seq
//   Directed and randomized bench for pwr_seq with NUM_STAGES=4, ON_DELAY=3,
//   OFF_DELAY=2. A reference model tracks the stage level and a ramp direction
//   with plain integer arithmetic and is compared after every clock edge.
module tb_pwr_seq;

    localparam int N    = 4;
    localparam int DON  = 3;
    localparam int DOFF = 2;

    logic         clk_i;
    logic         arst_ni;
    logic         req_i;
    logic [N-1:0] en_o;
    logic         on_o;
    logic         off_o;
    logic         busy_o;

    int n_checks;
    int n_pass;

    // Reference model: level, ramp direction (+1 up, -1 down, 0 settled) and
    // cycles elapsed since the ramp started or last stepped.
    int m_lvl;
    int m_dir;
    int m_age;

    pwr_seq #(
        .NUM_STAGES (N),
        .ON_DELAY   (DON),
        .OFF_DELAY  (DOFF)
    ) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .req_i   (req_i),
        .en_o    (en_o),
        .on_o    (on_o),
        .off_o   (off_o),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lvl = 0;
        m_dir = 0;
        m_age = 0;
    endtask

    task automatic model_step(input logic r);
        int want;
        int delay;
        want = r ? 1 : -1;
        if (m_dir == 0) begin
            if ((r && m_lvl == 0) || (!r && m_lvl == N)) begin
                m_dir = want;
                m_age = 0;
            end
        end else if (m_dir != want) begin
            if ((want > 0 && m_lvl == N) || (want < 0 && m_lvl == 0)) m_dir = 0;
            else m_dir = want;
            m_age = 0;
        end else begin
            delay = (m_dir > 0) ? DON : DOFF;
            m_age++;
            if (m_age == delay) begin
                m_lvl += m_dir;
                m_age = 0;
                if (m_lvl == 0 || m_lvl == N) m_dir = 0;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_en"},     int'(en_o),   (1 << m_lvl) - 1);
        chk({tag, "_on"},     int'(on_o),   (m_dir == 0 && m_lvl == N) ? 1 : 0);
        chk({tag, "_off"},    int'(off_o),  (m_dir == 0 && m_lvl == 0) ? 1 : 0);
        chk({tag, "_busy"},   int'(busy_o), (m_dir != 0) ? 1 : 0);
        chk({tag, "_onehot"}, int'(on_o) + int'(off_o) + int'(busy_o), 1);
    endtask

    // One rising edge with the current req_i, then compare against the model.
    task automatic edge_chk(input string tag);
        @(posedge clk_i);
        model_step(req_i);
        #1;
        chk_model(tag);
    endtask

    // Assert reset between edges and check outputs before any edge occurs.
    task automatic mid_reset(input string tag);
        #2;
        arst_ni = 1'b0;
        #1;
        chk({tag, "_en"},   int'(en_o),   0);
        chk({tag, "_off"},  int'(off_o),  1);
        chk({tag, "_on"},   int'(on_o),   0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        model_reset();
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    initial begin
        int hold;
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        arst_ni = 1'b0;
        req_i   = 1'b0;

        // Reset held: outputs settled, req_i ignored.
        #2;
        chk("rst_en",   int'(en_o),   0);
        chk("rst_off",  int'(off_o),  1);
        chk("rst_busy", int'(busy_o), 0);
        req_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_hold_en",  int'(en_o),  0);
        chk("rst_hold_off", int'(off_o), 1);
        req_i = 1'b0;
        @(negedge clk_i);
        arst_ni = 1'b1;

        // Power-up: stage every 3 edges, ON at edge 12.
        req_i = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            edge_chk("up");
            chk("up_en_tbl",   int'(en_o),   (1 << (e / 3)) - 1);
            chk("up_busy_tbl", int'(busy_o), (e <= 11) ? 1 : 0);
        end
        chk("up_on_tbl", int'(on_o), 1);
        repeat (3) edge_chk("on_hold");

        // Power-down: stage every 2 edges, OFF at edge 8.
        req_i = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            edge_chk("dn");
            chk("dn_en_tbl", int'(en_o), (1 << (4 - e / 2)) - 1);
        end
        chk("dn_off_tbl", int'(off_o), 1);
        repeat (2) edge_chk("off_hold");

        // Reversal at edge 7 with two stages up.
        req_i = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            if (e == 7) req_i = 1'b0;
            edge_chk("rev");
            if (e == 7) begin
                chk("rev_en7",   int'(en_o),   4'b0011);
                chk("rev_busy7", int'(busy_o), 1);
            end
            if (e == 9)  chk("rev_en9",  int'(en_o), 4'b0001);
            if (e == 11) begin
                chk("rev_en11",  int'(en_o),  4'b0000);
                chk("rev_off11", int'(off_o), 1);
            end
        end

        // Glitch: one-cycle request.
        req_i = 1'b1;
        edge_chk("gl0");
        chk("gl_busy0", int'(busy_o), 1);
        chk("gl_en0",   int'(en_o),   0);
        req_i = 1'b0;
        edge_chk("gl1");
        chk("gl_off1",  int'(off_o),  1);
        chk("gl_busy1", int'(busy_o), 0);
        edge_chk("gl2");

        // Collision: reversal on the edge where the second stage is due.
        req_i = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            if (e == 6) req_i = 1'b0;
            edge_chk("col");
        end
        chk("col_en6",   int'(en_o),   4'b0001);
        chk("col_busy6", int'(busy_o), 1);
        repeat (3) edge_chk("col_tail");
        chk("col_off", int'(off_o), 1);

        // Reset asserted mid power-up.
        req_i = 1'b1;
        for (int e = 0; e <= 7; e++) edge_chk("mr_up");
        mid_reset("mr");
        edge_chk("mr_restart");
        chk("mr_restart_busy", int'(busy_o), 1);

        // Randomized request levels, occasional mid-run reset.
        for (int blk = 0; blk < 60; blk++) begin
            req_i = 1'($urandom_range(0, 1));
            hold  = int'($urandom_range(1, 14));
            for (int c = 0; c < hold; c++) edge_chk("rnd");
            if ($urandom_range(0, 14) == 0) mid_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
